// File: rtl/ittage_write_sched.sv
// Write-port scheduler for one ITTAGE bank: buffers update writes in an in-order
// queue and interleaves them with the useful-bit clear sweep in lookup-free cycles.
module ittage_write_sched #(
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [IDX_W-1:0]         upd_idx,
    input  logic [DATA_W-1:0]        upd_data,
    input  logic                     lookup_en,
    input  logic                     reset_u_req,
    output logic                     wr_en,
    output logic [IDX_W-1:0]         wr_idx,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     wr_clear_u,
    output logic                     sweep_busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, young_ptr;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   sweep_ptr_q, sweep_ptr_d;
    logic               rr_q, rr_d;
    logic [IDX_W-1:0]   idx_mem_q  [DEPTH];
    logic [DATA_W-1:0]  data_mem_q [DEPTH];
    logic               q_nonempty, sweep_act, grant_q, grant_s;
    logic               push, coalesce, alloc;

    assign q_nonempty = (count_q != '0);
    assign sweep_act  = (state_q == SWEEP);
    assign upd_ready  = (count_q < CNT_W'(DEPTH));
    assign sweep_busy = sweep_act;
    assign count      = count_q;

    // rr = 0 gives the sweep priority on the next contended cycle.
    always_comb begin
        grant_q = 1'b0;
        grant_s = 1'b0;
        rr_d    = rr_q;
        if (!lookup_en) begin
            if (q_nonempty && sweep_act) begin
                if (rr_q) grant_q = 1'b1;
                else      grant_s = 1'b1;
                rr_d = ~rr_q;
            end else if (q_nonempty) begin
                grant_q = 1'b1;
            end else if (sweep_act) begin
                grant_s = 1'b1;
            end
        end
    end

    // A push may only merge into the youngest entry if that entry stays resident.
    assign young_ptr = tail_q - PTR_W'(1);
    assign push      = upd_valid & upd_ready;
    assign coalesce  = push && q_nonempty && (idx_mem_q[young_ptr] == upd_idx)
                       && !(grant_q && (count_q == CNT_W'(1)));
    assign alloc     = push & ~coalesce;

    assign tail_d  = alloc   ? tail_q + PTR_W'(1) : tail_q;
    assign head_d  = grant_q ? head_q + PTR_W'(1) : head_q;
    assign count_d = count_q + CNT_W'(alloc) - CNT_W'(grant_q);

    assign wr_en      = grant_q | grant_s;
    assign wr_clear_u = grant_s;
    assign wr_idx     = grant_s ? sweep_ptr_q : idx_mem_q[head_q];
    assign wr_data    = grant_s ? '0 : data_mem_q[head_q];

    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        case (state_q)
            IDLE: begin
                if (reset_u_req) begin
                    state_d     = SWEEP;
                    sweep_ptr_d = '0;
                end
            end
            SWEEP: begin
                if (grant_s) begin
                    sweep_ptr_d = sweep_ptr_q + IDX_W'(1);
                    if (sweep_ptr_q == '1) begin
                        state_d     = IDLE;
                        sweep_ptr_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sweep_ptr_q <= '0;
            rr_q        <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
            rr_q        <= rr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (alloc) begin
            idx_mem_q[tail_q]  <= upd_idx;
            data_mem_q[tail_q] <= upd_data;
        end else if (coalesce) begin
            data_mem_q[young_ptr] <= upd_data;
        end
    end

endmodule

// File: tb/tb_ittage_write_sched.sv
// Directed bench for ittage_write_sched: expected writes (with their cycle) are
// queued by the stimulus and matched by a monitor whenever wr_en is seen.
module tb_ittage_write_sched;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 32;
    localparam int EW     = 16 + 1 + IDX_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              upd_valid, upd_ready;
    logic [IDX_W-1:0]  upd_idx;
    logic [DATA_W-1:0] upd_data;
    logic              lookup_en, reset_u_req;
    logic              wr_en, wr_clear_u, sweep_busy;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_got, mon_exp;

    ittage_write_sched #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_idx(upd_idx), .upd_data(upd_data),
        .lookup_en(lookup_en), .reset_u_req(reset_u_req),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_clear_u(wr_clear_u), .sweep_busy(sweep_busy), .count(count)
    );

    // Clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed write must be the next expected one, in its cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && wr_en === 1'b1) begin
            checks++;
            mon_got = {cyc[15:0], wr_clear_u, wr_idx, wr_data};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got cyc=%0d clr=%0b idx=%0d data=%h, required no write",
                         cyc, wr_clear_u, wr_idx, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                begin
                    errors++;
                    $display("FAIL write: got cyc=%0d clr=%0b idx=%0d data=%h, required cyc=%0d clr=%0b idx=%0d data=%h",
                             mon_got[EW-1 -: 16], mon_got[DATA_W+IDX_W], mon_got[DATA_W +: IDX_W], mon_got[DATA_W-1:0],
                             mon_exp[EW-1 -: 16], mon_exp[DATA_W+IDX_W], mon_exp[DATA_W +: IDX_W], mon_exp[DATA_W-1:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d,
                         input logic lk, input logic req);
        upd_valid   = v;
        upd_idx     = idx;
        upd_data    = d;
        lookup_en   = lk;
        reset_u_req = req;
    endtask

    task automatic expect_wr(input int c, input logic clr, input logic [IDX_W-1:0] idx,
                             input logic [DATA_W-1:0] d);
        logic [15:0] c16;
        c16 = c[15:0];
        exp_q.push_back({c16, clr, idx, d});
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [IDX_W-1:0]  t1_idx [5] = '{3'd5, 3'd9 - 3'd0, 3'd3, 3'd6, 3'd6};
    logic [DATA_W-1:0] t1_dat [5] = '{32'h55, 32'h99, 32'h33, 32'h66, 32'h67};
    logic [IDX_W-1:0]  t3_idx [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
    logic [DATA_W-1:0] t3_dat [5] = '{32'hA1, 32'hA2, 32'hA3, 32'hBB, 32'hA4};

    initial begin
        int t0;
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset state
        do_reset();
        check("rst_count", count, 0);
        check("rst_ready", upd_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_clear_u", wr_clear_u, 0);
        check("rst_sweep_busy", sweep_busy, 0);

        // Basic drain; the repeated idx 6 hits an entry being popped, so no merge
        t0 = cyc;
        for (int k = 0; k < 5; k++) expect_wr(t0 + 1 + k, 1'b0, t1_idx[k], t1_dat[k]);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, t1_idx[k], t1_dat[k], 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drain("basic");
        check("basic_count_end", count, 0);

        // Lookup blocking
        do_reset();
        t0 = cyc;
        expect_wr(t0 + 5, 1'b0, 3'd7, 32'h77);
        drive(1'b1, 3'd7, 32'h77, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drain("lookup");

        // Full and coalescing
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, t3_idx[k], t3_dat[k], 1'b1, 1'b0);
            step();
            if (k == 3) check("coalesce_count", count, 3);
        end
        check("full_count", count, 4);
        check("full_ready", upd_ready, 0);
        drive(1'b1, 3'd5, 32'hC5, 1'b1, 1'b0);
        step();
        drive(1'b1, 3'd4, 32'hCC, 1'b1, 1'b0);
        step();
        check("refused_count", count, 4);
        t0 = cyc;
        expect_wr(t0,     1'b0, 3'd1, 32'hA1);
        expect_wr(t0 + 1, 1'b0, 3'd2, 32'hA2);
        expect_wr(t0 + 2, 1'b0, 3'd3, 32'hBB);
        expect_wr(t0 + 3, 1'b0, 3'd4, 32'hA4);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drain("full");
        check("full_count_end", count, 0);

        // Sweep alone, with an ignored second request at cycle 4
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 8; k++) expect_wr(t0 + 1 + k, 1'b1, IDX_W'(k), '0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, '0, '0, 1'b0, (k == 0 || k == 4));
            if (k == 1 || k == 8 || k == 9)
                check($sformatf("sweep_busy_c%0d", k), sweep_busy, (k <= 8) ? 1 : 0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drain("sweep");

        // Contention with one lookup cycle inserted at t0+4
        do_reset();
        t0 = cyc;
        expect_wr(t0 + 1, 1'b1, 3'd0, '0);
        expect_wr(t0 + 2, 1'b1, 3'd1, '0);
        expect_wr(t0 + 3, 1'b0, 3'd5, 32'hE5);
        expect_wr(t0 + 5, 1'b1, 3'd2, '0);
        expect_wr(t0 + 6, 1'b0, 3'd6, 32'hE6);
        expect_wr(t0 + 7, 1'b1, 3'd3, '0);
        expect_wr(t0 + 8, 1'b0, 3'd2, 32'hE2);
        for (int k = 4; k < 8; k++) expect_wr(t0 + 5 + k, 1'b1, IDX_W'(k), '0);
        for (int k = 0; k < 14; k++) begin
            case (k)
                0:       drive(1'b0, '0,   '0,      1'b0, 1'b1);
                1:       drive(1'b1, 3'd5, 32'hE5,  1'b0, 1'b0);
                2:       drive(1'b1, 3'd6, 32'hE6,  1'b0, 1'b0);
                3:       drive(1'b1, 3'd2, 32'hE2,  1'b0, 1'b0);
                4:       drive(1'b0, '0,   '0,      1'b1, 1'b0);
                default: drive(1'b0, '0,   '0,      1'b0, 1'b0);
            endcase
            if (k == 13) check("contend_busy_end", sweep_busy, 0);
            step();
        end
        drain("contend");

        // Reset mid-operation at sweep_ptr=3, count=2
        do_reset();
        t0 = cyc;
        for (int k = 0; k < 3; k++) expect_wr(t0 + 1 + k, 1'b1, IDX_W'(k), '0);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step();
        drive(1'b1, 3'd1, 32'hD1, 1'b1, 1'b0);
        step();
        drive(1'b1, 3'd2, 32'hD2, 1'b1, 1'b0);
        step();
        check("pre_rst_count", count, 2);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("post_rst_count", count, 0);
        check("post_rst_busy", sweep_busy, 0);
        check("post_rst_wr_en", wr_en, 0);
        check("post_rst_ready", upd_ready, 1);
        for (int k = 0; k < 4; k++) step();
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
